// File: rtl/regfile_core.sv
// rtl/regfile_core.sv - 31 x DATA_W register file with hard-wired zero at the all-ones address.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_core #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [DATA_W-1:0] wd3,
  input  logic              we3,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZR_ADDR = '1;

  // No storage exists for the zero register; the array stops one short.
  logic [DATA_W-1:0] regs [NREG-1];
  logic              wr_en;
  logic              fwd1;
  logic              fwd2;

  assign wr_en = we3 && (wa3 != ZR_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG - 1; i++) begin
        regs[i] <= DATA_W'(i);
      end
    end else if (wr_en) begin
      regs[wa3] <= wd3;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign fwd1 = wr_en && (ra1 == wa3);
  assign fwd2 = wr_en && (ra2 == wa3);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  // The zero check comes first so the unbacked address never indexes the array.
  assign rd1 = (ra1 == ZR_ADDR) ? '0 : (fwd1 ? wd3 : regs[ra1]);
  assign rd2 = (ra2 == ZR_ADDR) ? '0 : (fwd2 ? wd3 : regs[ra2]);

endmodule

// File: tb/tb_regfile_core.sv
// tb/tb_regfile_core.sv - directed bench for regfile_core, honours REGFILE_BYPASS_EN.
module tb_regfile_core;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ra1, ra2, wa3;
  logic [63:0] wd3;
  logic        we3;
  logic [63:0] rd1, rd2;

  int passed = 0;
  int total  = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_core #(.DATA_W(64), .ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (ra1),
    .ra2   (ra2),
    .wa3   (wa3),
    .wd3   (wd3),
    .we3   (we3),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    logic [63:0] exp_v;
    rst_n = 1'b0;
    we3   = 1'b1;
    wa3   = 5'd3;
    wd3   = 64'd555;
    ra1   = 5'd3;
    ra2   = 5'd31;

    // Edge during reset must not write
    @(posedge clk); #1;
    we3 = 1'b0;
    #1;
    check("reset_no_write", rd1, 64'd3);
    check("reset_xzr", rd2, 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(i);
      #1;
      exp_v = (i == 31) ? 64'd0 : 64'(i);
      check($sformatf("sweep_rd1_%0d", i), rd1, exp_v);
      check($sformatf("sweep_rd2_%0d", i), rd2, exp_v);
    end

    // Write and overwrite X6
    @(negedge clk);
    we3 = 1'b1; wa3 = 5'd6; wd3 = 64'd69; ra1 = 5'd6; ra2 = 5'd5;
    #1;
    check("pre_edge_x6", rd1, BYP ? 64'd69 : 64'd6);
    check("pre_edge_other_port", rd2, 64'd5);
    @(posedge clk); #1;
    check("write_x6_69", rd1, 64'd69);
    @(negedge clk);
    wd3 = 64'd70;
    #1;
    check("negedge_wd3_change", rd1, BYP ? 64'd70 : 64'd69);
    #2;
    wd3 = 64'd71;
    @(posedge clk); #1;
    we3 = 1'b0;
    #1;
    check("overwrite_x6_71", rd1, 64'd71);

    // XZR write discarded
    @(negedge clk);
    we3 = 1'b1; wa3 = 5'd31; wd3 = 64'd75; ra1 = 5'd31; ra2 = 5'd31;
    #1;
    check("xzr_pre_edge", rd1, 64'd0);
    @(posedge clk); #1;
    we3 = 1'b0;
    #1;
    check("xzr_rd1", rd1, 64'd0);
    check("xzr_rd2", rd2, 64'd0);
    for (int i = 0; i < 31; i++) begin
      ra1 = 5'(i);
      #1;
      check($sformatf("post_xzr_x%0d", i), rd1, (i == 6) ? 64'd71 : 64'(i));
    end

    // Write disable
    @(negedge clk);
    we3 = 1'b0; wa3 = 5'd6; wd3 = 64'd72; ra1 = 5'd6;
    @(posedge clk); #1;
    check("we3_low_x6", rd1, 64'd71);

    // Forwarding on port 2
    @(negedge clk);
    we3 = 1'b1; wa3 = 5'd10; wd3 = 64'd99; ra2 = 5'd10; ra1 = 5'd6;
    #1;
    check("bypass_rd2", rd2, BYP ? 64'd99 : 64'd10);
    check("bypass_rd1_unrelated", rd1, 64'd71);
    @(posedge clk); #1;
    we3 = 1'b0;
    #1;
    check("after_edge_x10", rd2, 64'd99);

    // Full-width data, both ports on same address
    @(negedge clk);
    we3 = 1'b1; wa3 = 5'd0; wd3 = 64'hDEAD_BEEF_CAFE_F00D;
    @(posedge clk); #1;
    we3 = 1'b0; ra1 = 5'd0; ra2 = 5'd0;
    #1;
    check("wide_rd1", rd1, 64'hDEAD_BEEF_CAFE_F00D);
    check("wide_rd2", rd2, 64'hDEAD_BEEF_CAFE_F00D);

    // Async reset mid-cycle
    ra1 = 5'd6; ra2 = 5'd10;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_x6", rd1, 64'd6);
    check("async_reset_x10", rd2, 64'd10);
    we3 = 1'b1; wa3 = 5'd0; wd3 = 64'd123; ra2 = 5'd0;
    @(posedge clk); #1;
    we3 = 1'b0;
    #1;
    check("reset_blocks_write", rd2, 64'd0);

    // Writes resume after reset release
    @(negedge clk);
    rst_n = 1'b1;
    we3 = 1'b1; wa3 = 5'd6; wd3 = 64'd124;
    @(posedge clk); #1;
    we3 = 1'b0;
    #1;
    check("write_after_reset", rd1, 64'd124);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
